// File: rtl/aes_core_driver.sv
// ---------------------------------------------------------------------------
// aes_core_driver
//   Host-side initiator for aes_core. Converts valid/ready key and block
//   streams into aes_core load pulses and start strobes. aes_core has no done
//   flag, so a fixed-latency timer decides when its result is stable. The
//   result is then captured and offered on a valid/ready output stream.
//   At most one block is in flight. A key can only change between blocks.
//
// Parameters
//   CORE_LATENCY  cycles from the start strobe to a stable core result (>=1)
//   KEY_SETUP     idle cycles after set_key before a block may load (>=1)
//   CNT_W         width of the blocks_done counter
//
// Ports
//   clk, reset_n                    clock (rising edge), async active-low reset
//   key_valid/key_ready/key_data    host key stream (AES-128 key)
//   in_valid/in_ready/in_data       host block stream
//   in_decrypt                      0 = encrypt, 1 = decrypt; sampled with in_data
//   out_valid/out_ready/out_data    result stream (ciphertext or plaintext)
//   key_loaded                      a key has been loaded and its setup time is over
//   busy                            FSM is not idle
//   blocks_done                     results handed off (wraps)
//   core_*                          aes_core control, key, text and result buses
// ---------------------------------------------------------------------------
module aes_core_driver #(
    parameter int unsigned CORE_LATENCY = 12,
    parameter int unsigned KEY_SETUP    = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic [127:0]     key_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_data,
    input  logic             in_decrypt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic             key_loaded,
    output logic             busy,
    output logic [CNT_W-1:0] blocks_done,
    output logic             core_set_key,
    output logic [127:0]     core_key,
    output logic             core_set_plain_text,
    output logic             core_set_cipher_text,
    output logic [127:0]     core_text,
    output logic             core_start_enc,
    output logic             core_start_dec,
    input  logic [127:0]     core_plain_out,
    input  logic [127:0]     core_cipher_out
);

    // One shared timer covers both the key setup wait and the core latency wait.
    // The largest value ever loaded is TMR_MAX-1.
    localparam int unsigned TMR_MAX = (CORE_LATENCY > KEY_SETUP) ? CORE_LATENCY : KEY_SETUP;
    localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    typedef enum logic [2:0] {
        IDLE,
        KEY_LOAD,
        KEY_WAIT,
        LOAD,
        START,
        WAIT,
        HOLD
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [TMR_W-1:0]  tmr;
    logic              dec_q;
    logic              key_accept;
    logic              blk_accept;
    logic              out_accept;

    // ------------------------------------------------------------------
    // Next state and Moore outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next           = state;
        key_ready            = 1'b0;
        in_ready             = 1'b0;
        core_set_key         = 1'b0;
        core_set_plain_text  = 1'b0;
        core_set_cipher_text = 1'b0;
        core_start_enc       = 1'b0;
        core_start_dec       = 1'b0;
        key_accept           = 1'b0;
        blk_accept           = 1'b0;
        out_accept           = 1'b0;
        busy                 = (state != IDLE);

        case (state)
            IDLE: begin
                key_ready = 1'b1;
                // A pending key always beats a pending block.
                in_ready  = key_loaded & ~key_valid;
                if (key_valid) begin
                    key_accept = 1'b1;
                    state_next = KEY_LOAD;
                end else if (in_valid && key_loaded) begin
                    blk_accept = 1'b1;
                    state_next = LOAD;
                end
            end
            KEY_LOAD: begin
                core_set_key = 1'b1;
                state_next   = KEY_WAIT;
            end
            KEY_WAIT: begin
                if (tmr == '0) begin
                    state_next = IDLE;
                end
            end
            LOAD: begin
                core_set_plain_text  = ~dec_q;
                core_set_cipher_text = dec_q;
                state_next           = START;
            end
            START: begin
                core_start_enc = ~dec_q;
                core_start_dec = dec_q;
                state_next     = WAIT;
            end
            WAIT: begin
                if (tmr == '0) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_accept = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State, timer and data registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            tmr         <= '0;
            dec_q       <= 1'b0;
            core_key    <= '0;
            core_text   <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            key_loaded  <= 1'b0;
            blocks_done <= '0;
        end else begin
            state <= state_next;

            if (key_accept) begin
                core_key <= key_data;
            end
            if (blk_accept) begin
                core_text <= in_data;
                dec_q     <= in_decrypt;
            end

            case (state)
                KEY_LOAD: tmr <= TMR_W'(KEY_SETUP - 1);
                KEY_WAIT: begin
                    if (tmr == '0) begin
                        key_loaded <= 1'b1;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                START: tmr <= TMR_W'(CORE_LATENCY - 1);
                WAIT: begin
                    if (tmr == '0) begin
                        out_data  <= dec_q ? core_plain_out : core_cipher_out;
                        out_valid <= 1'b1;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                HOLD: begin
                    if (out_accept) begin
                        out_valid   <= 1'b0;
                        blocks_done <= blocks_done + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_core_driver.sv
module tb_aes_core_driver;

    localparam int LAT = 12;
    localparam int KS  = 2;
    localparam int CW  = 16;

    localparam logic [127:0] K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P0  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C0  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2  = 128'hfedcba98765432100123456789abcdef;
    localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] P2  = 128'hdeadbeefcafef00d0badc0de12345678;
    localparam logic [127:0] P3  = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    localparam logic [127:0] MIX = 128'h5a5a5a5ac3c3c3c3a5a5a5a53c3c3c3c;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            key_valid = 1'b0;
    logic            key_ready;
    logic [127:0]    key_data = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [127:0]    in_data = '0;
    logic            in_decrypt = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [127:0]    out_data;
    logic            key_loaded;
    logic            busy;
    logic [CW-1:0]   blocks_done;
    logic            core_set_key;
    logic [127:0]    core_key;
    logic            core_set_plain_text;
    logic            core_set_cipher_text;
    logic [127:0]    core_text;
    logic            core_start_enc;
    logic            core_start_dec;
    logic [127:0]    core_plain_out = '0;
    logic [127:0]    core_cipher_out = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [127:0] exp_q[$];
    logic [127:0] tb_key = '0;

    int n_enc = 0, n_dec = 0, n_setkey = 0, n_load = 0;

    aes_core_driver #(
        .CORE_LATENCY(LAT),
        .KEY_SETUP(KS),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .key_valid(key_valid),
        .key_ready(key_ready),
        .key_data(key_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_decrypt(in_decrypt),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .key_loaded(key_loaded),
        .busy(busy),
        .blocks_done(blocks_done),
        .core_set_key(core_set_key),
        .core_key(core_key),
        .core_set_plain_text(core_set_plain_text),
        .core_set_cipher_text(core_set_cipher_text),
        .core_text(core_text),
        .core_start_enc(core_start_enc),
        .core_start_dec(core_start_dec),
        .core_plain_out(core_plain_out),
        .core_cipher_out(core_cipher_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in cipher: the FIPS-197 vector is exact, anything else uses a
    // reversible mixing so the driver's data path can still be checked.
    function automatic logic [127:0] f_enc(input logic [127:0] k, input logic [127:0] p);
        if (k == K0 && p == P0) return C0;
        return p ^ {k[63:0], k[127:64]} ^ MIX;
    endfunction

    function automatic logic [127:0] f_dec(input logic [127:0] k, input logic [127:0] c);
        if (k == K0 && c == C0) return P0;
        return c ^ {k[63:0], k[127:64]} ^ MIX;
    endfunction

    // aes_core model: result appears LAT-1 edges after the start strobe is
    // sampled, i.e. just before the driver's capture edge; earlier it is noise.
    logic [127:0] m_key = '0, m_text = '0;
    logic         m_dec = 1'b0;
    int           m_cnt = 0;

    always @(posedge clk) begin
        if (core_set_key) m_key <= core_key;
        if (core_set_plain_text || core_set_cipher_text) m_text <= core_text;
        if (core_start_enc || core_start_dec) begin
            m_dec           <= core_start_dec;
            m_cnt           <= LAT - 1;
            core_cipher_out <= {$urandom, $urandom, $urandom, $urandom};
            core_plain_out  <= {$urandom, $urandom, $urandom, $urandom};
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                if (m_dec) begin
                    core_plain_out  <= f_dec(m_key, m_text);
                    core_cipher_out <= {$urandom, $urandom, $urandom, $urandom};
                end else begin
                    core_cipher_out <= f_enc(m_key, m_text);
                    core_plain_out  <= {$urandom, $urandom, $urandom, $urandom};
                end
            end
        end
    end

    always @(posedge clk) begin
        if (core_start_enc)                              n_enc    <= n_enc + 1;
        if (core_start_dec)                              n_dec    <= n_dec + 1;
        if (core_set_key)                                n_setkey <= n_setkey + 1;
        if (core_set_plain_text || core_set_cipher_text) n_load   <= n_load + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------
    // Drivers (all start and end 1 time unit after a rising edge)
    // ---------------------------------------------------------------
    task automatic do_reset();
        reset_n    = 1'b0;
        key_valid  = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        in_decrypt = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        tb_key = '0;
        exp_q.delete();
    endtask

    task automatic drive_key(input logic [127:0] k, output bit ok, output int acc);
        ok        = 1'b0;
        key_data  = k;
        key_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (key_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        acc       = cyc;
        key_valid = 1'b0;
        if (ok) tb_key = k;
    endtask

    task automatic drive_block(input logic [127:0] d, input logic dec, output bit ok, output int acc);
        ok         = 1'b0;
        in_data    = d;
        in_decrypt = dec;
        in_valid   = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        acc      = cyc;
        in_valid = 1'b0;
        if (ok) exp_q.push_back(dec ? f_dec(tb_key, d) : f_enc(tb_key, d));
    endtask

    // Offers key and block together; reports when each was accepted and
    // whether in_ready was held low while the key was being taken.
    task automatic key_then_block(input logic [127:0] k, input logic [127:0] d,
                                  output bit ok, output int kc, output int bc,
                                  output logic ir_at_key);
        bit kok, bok;
        kok        = 1'b0;
        bok        = 1'b0;
        ir_at_key  = 1'b0;
        key_data   = k;
        key_valid  = 1'b1;
        in_data    = d;
        in_decrypt = 1'b0;
        in_valid   = 1'b1;
        for (int i = 0; i < 50 && !kok; i++) begin
            @(negedge clk);
            if (key_ready) begin
                kok       = 1'b1;
                ir_at_key = in_ready;
            end
            @(posedge clk);
            #1;
        end
        kc        = cyc;
        key_valid = 1'b0;
        if (kok) tb_key = k;
        for (int i = 0; i < 50 && !bok; i++) begin
            @(negedge clk);
            if (in_ready) bok = 1'b1;
            @(posedge clk);
            #1;
        end
        bc       = cyc;
        in_valid = 1'b0;
        if (bok) exp_q.push_back(f_enc(tb_key, d));
        ok = kok && bok;
    endtask

    task automatic get_result(output logic [127:0] data, output bit ok, output int first);
        ok        = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        first     = cyc;
        data      = out_data;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    // ---------------------------------------------------------------
    // Scenarios
    // ---------------------------------------------------------------
    task automatic test_reset();
        do_reset();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || key_loaded !== 1'b0 || blocks_done !== '0) begin
            errors++;
            $display("FAIL reset_status: out_valid=%b busy=%b key_loaded=%b blocks_done=%0d required 0 0 0 0",
                     out_valid, busy, key_loaded, blocks_done);
        end
        checks++;
        if (out_data !== '0 || core_key !== '0 || core_text !== '0) begin
            errors++;
            $display("FAIL reset_data: out_data=%h core_key=%h core_text=%h required all zero",
                     out_data, core_key, core_text);
        end
        checks++;
        if (key_ready !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: key_ready=%b in_ready=%b required 1 0", key_ready, in_ready);
        end
    endtask

    task automatic test_encrypt();
        bit ok;
        int kc, ac, rc, e0;
        logic [127:0] got, exp;
        drive_key(K0, ok, kc);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL enc_key_accept: accepted=%0b required=1", ok);
        end
        e0 = n_enc;
        drive_block(P0, 1'b0, ok, ac);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL enc_block_accept: accepted=%0b required=1", ok);
        end
        get_result(got, ok, rc);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL enc_out_timeout: out_valid seen=%0b required=1", ok);
        end
        exp = 'x;
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL enc_data: got=%h required=%h", got, exp);
        end
        checks++;
        if (rc - ac !== LAT + 2) begin
            errors++;
            $display("FAIL enc_latency: got=%0d required=%0d", rc - ac, LAT + 2);
        end
        checks++;
        if (blocks_done !== CW'(1) || out_valid !== 1'b0 || n_enc - e0 !== 1) begin
            errors++;
            $display("FAIL enc_after: blocks_done=%0d out_valid=%b start_enc=%0d required 1 0 1",
                     blocks_done, out_valid, n_enc - e0);
        end
    endtask

    task automatic test_decrypt();
        bit ok, ok2;
        int ac, rc, e0, d0;
        logic [127:0] got, exp;
        e0 = n_enc;
        d0 = n_dec;
        drive_block(C0, 1'b1, ok, ac);
        get_result(got, ok2, rc);
        checks++;
        if (!ok || !ok2) begin
            errors++;
            $display("FAIL dec_handshake: accept=%0b result=%0b required 1 1", ok, ok2);
        end
        exp = 'x;
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL dec_data: got=%h required=%h", got, exp);
        end
        checks++;
        if (n_dec - d0 !== 1 || n_enc - e0 !== 0) begin
            errors++;
            $display("FAIL dec_strobes: start_dec=%0d start_enc=%0d required 1 0", n_dec - d0, n_enc - e0);
        end
        checks++;
        if (blocks_done !== CW'(2)) begin
            errors++;
            $display("FAIL dec_count: blocks_done=%0d required 2", blocks_done);
        end
    endtask

    task automatic test_no_key_stall();
        bit ok, ok2;
        int kc, bc, rc, viol, s0;
        logic ir;
        logic [127:0] got, exp;
        do_reset();
        s0         = n_enc + n_dec + n_setkey + n_load;
        viol       = 0;
        in_data    = P1;
        in_decrypt = 1'b0;
        in_valid   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready !== 1'b0) viol++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (viol !== 0 || n_enc + n_dec + n_setkey + n_load - s0 !== 0) begin
            errors++;
            $display("FAIL nokey_stall: in_ready high cycles=%0d core strobes=%0d required 0 0",
                     viol, n_enc + n_dec + n_setkey + n_load - s0);
        end
        key_then_block(K1, P1, ok, kc, bc, ir);
        checks++;
        if (!ok || bc - kc !== KS + 2) begin
            errors++;
            $display("FAIL nokey_setup_gap: ok=%0b gap=%0d required 1 %0d", ok, bc - kc, KS + 2);
        end
        get_result(got, ok2, rc);
        exp = 'x;
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        checks++;
        if (!ok2 || got !== exp) begin
            errors++;
            $display("FAIL nokey_data: result=%0b got=%h required=%h", ok2, got, exp);
        end
    endtask

    task automatic test_simultaneous();
        bit ok, ok2;
        int kc, bc, rc;
        logic ir;
        logic [127:0] got, exp;
        key_then_block(K2, P2, ok, kc, bc, ir);
        checks++;
        if (!ok || ir !== 1'b0 || bc - kc !== KS + 2) begin
            errors++;
            $display("FAIL simul_order: ok=%0b in_ready_at_key=%b gap=%0d required 1 0 %0d",
                     ok, ir, bc - kc, KS + 2);
        end
        checks++;
        if (core_key !== K2) begin
            errors++;
            $display("FAIL simul_core_key: got=%h required=%h", core_key, K2);
        end
        get_result(got, ok2, rc);
        exp = 'x;
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        checks++;
        if (!ok2 || got !== exp) begin
            errors++;
            $display("FAIL simul_data: result=%0b got=%h required=%h", ok2, got, exp);
        end
    endtask

    task automatic test_backpressure();
        bit ok, seen;
        int ac, viol, bd0, sk0;
        logic [127:0] held, exp;
        bd0 = int'(blocks_done);
        drive_block(P3, 1'b0, ok, ac);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (out_valid) seen = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        checks++;
        if (!ok || !seen) begin
            errors++;
            $display("FAIL bp_handshake: accept=%0b out_valid seen=%0b required 1 1", ok, seen);
        end
        held      = out_data;
        sk0       = n_setkey;
        viol      = 0;
        key_data  = K0;
        key_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0 || key_ready !== 1'b0) viol++;
        end
        key_valid = 1'b0;
        checks++;
        if (viol !== 0 || n_setkey - sk0 !== 0) begin
            errors++;
            $display("FAIL bp_hold: unstable cycles=%0d set_key pulses=%0d required 0 0", viol, n_setkey - sk0);
        end
        exp = 'x;
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        checks++;
        if (held !== exp) begin
            errors++;
            $display("FAIL bp_data: got=%h required=%h", held, exp);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || int'(blocks_done) !== bd0 + 1) begin
            errors++;
            $display("FAIL bp_release: out_valid=%b blocks_done=%0d required 0 %0d",
                     out_valid, blocks_done, bd0 + 1);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int ac, ov, s0;
        drive_block(P0, 1'b0, ok, ac);
        repeat (5) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if (!ok || busy !== 1'b0 || out_valid !== 1'b0 || key_loaded !== 1'b0 || blocks_done !== '0
            || core_key !== '0 || core_text !== '0 || out_data !== '0) begin
            errors++;
            $display("FAIL midreset_clear: accept=%0b busy=%b out_valid=%b key_loaded=%b blocks_done=%0d key=%h text=%h out=%h required all zero",
                     ok, busy, out_valid, key_loaded, blocks_done, core_key, core_text, out_data);
        end
        checks++;
        if (core_set_key || core_set_plain_text || core_set_cipher_text || core_start_enc || core_start_dec) begin
            errors++;
            $display("FAIL midreset_strobes: strobes=%b%b%b%b%b required 00000", core_set_key,
                     core_set_plain_text, core_set_cipher_text, core_start_enc, core_start_dec);
        end
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        s0      = n_enc + n_dec;
        ov      = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0 || key_loaded !== 1'b0) ov++;
        end
        checks++;
        if (ov !== 0 || n_enc + n_dec - s0 !== 0) begin
            errors++;
            $display("FAIL midreset_after: bad cycles=%0d starts=%0d required 0 0", ov, n_enc + n_dec - s0);
        end
    endtask

    initial begin
        test_reset();
        test_encrypt();
        test_decrypt();
        test_no_key_stall();
        test_simultaneous();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
